bitnet_sequencer: RTL and testbench

Parametrised successor to the BitNet control unit. It fetches 16-bit instructions, each with an opcode and an immediate. It drives a single unified memory port with a req/ack handshake across the data, weight and heap channels, and it drives an external compute port for interweave, backprop and stoch-grad. The immediate field sets pointers in one word, which replaces the two-word "NEXT" fetch. Jumps, halt and an optional hardware loop give the block control flow the previous generation lacked.

---
 rtl/bitnet_sequencer_if.sv | 24 ++
 rtl/bitnet_sequencer.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_bitnet_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bitnet_sequencer_if.sv
// rtl/bitnet_sequencer_if.sv - unified data/weight/heap memory port of the BitNet sequencer
interface bitnet_sequencer_if #(
  parameter int ADDR_SIZE = 8,
  parameter int WIDTH     = 1024
);
  logic                 mem_req_out;
  logic                 mem_ack_in;
  logic [1:0]           mem_ch_out;
  logic                 mem_we_out;
  logic [ADDR_SIZE-1:0] mem_addr_out;
  logic [WIDTH-1:0]     mem_wdata_out;
  logic [WIDTH-1:0]     mem_rdata_x_in;
  logic [WIDTH-1:0]     mem_rdata_y_in;

  modport master (
    output mem_req_out, mem_ch_out, mem_we_out, mem_addr_out, mem_wdata_out,
    input  mem_ack_in, mem_rdata_x_in, mem_rdata_y_in
  );

  modport slave (
    input  mem_req_out, mem_ch_out, mem_we_out, mem_addr_out, mem_wdata_out,
    output mem_ack_in, mem_rdata_x_in, mem_rdata_y_in
  );
endinterface

// File: rtl/bitnet_sequencer.sv
// rtl/bitnet_sequencer.sv - BitNet instruction sequencer with memory and compute handshakes
// Optional hardware loop (LOOP/ENDLOOP) enabled by defining BITNET_HW_LOOP_EN.
module bitnet_sequencer #(
  parameter int  PROGRAM_LENGTH = 256,
  parameter int  ADDR_SIZE      = 8,
  parameter int  WIDTH          = 1024,
  localparam int I_SIZE         = $clog2(PROGRAM_LENGTH)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  output logic [I_SIZE-1:0] instruction_addr_out,
  input  logic [15:0]       instruction_in,
  input  logic              instruction_valid_in,
  bitnet_sequencer_if.master mem,
  output logic              op_start_out,
  output logic [1:0]        op_sel_out,
  output logic [WIDTH-1:0]  x_out,
  output logic [WIDTH-1:0]  y_out,
  output logic [WIDTH-1:0]  w_out,
  input  logic [WIDTH-1:0]  op_result_in,
  input  logic              op_done_in,
  output logic [WIDTH-1:0]  inference_out,
  output logic              inference_valid_out,
  output logic              halted_out,
  output logic              illegal_out
);

  localparam logic [4:0] OPC_NOP     = 5'd0;
  localparam logic [4:0] OPC_JMP     = 5'd1;
  localparam logic [4:0] OPC_HALT    = 5'd2;
  localparam logic [4:0] OPC_SETP    = 5'd3;
  localparam logic [4:0] OPC_ADDP    = 5'd4;
  localparam logic [4:0] OPC_LOAD    = 5'd5;
  localparam logic [4:0] OPC_STORE   = 5'd6;
  localparam logic [4:0] OPC_ALU     = 5'd7;
  localparam logic [4:0] OPC_OP      = 5'd8;
  localparam logic [4:0] OPC_EMIT    = 5'd9;
`ifdef BITNET_HW_LOOP_EN
  localparam logic [4:0] OPC_LOOP    = 5'd10;
  localparam logic [4:0] OPC_ENDLOOP = 5'd11;
`endif

  typedef enum logic [1:0] {S_FETCH, S_WAIT_MEM, S_WAIT_OP, S_HALT} state_t;

  state_t               state, state_nxt;
  logic [I_SIZE-1:0]    ip, ip_nxt, ip_inc;
  logic [ADDR_SIZE-1:0] d_ptr, a_ptr, h_ptr, d_nxt, a_nxt, h_nxt, sel_ptr, new_ptr;
  logic [WIDTH-1:0]     x_reg, y_reg, w_reg, x_nxt, y_nxt, w_nxt;
  logic                 req_r, req_nxt, we_r, we_nxt;
  logic [1:0]           ch_r, ch_nxt;
  logic [ADDR_SIZE-1:0] addr_r, addr_nxt;
  logic [WIDTH-1:0]     wdata_r, wdata_nxt;
  logic [2:0]           lsub_r, lsub_nxt;
  logic [1:0]           osel_r, osel_nxt;
  logic                 start_r, start_nxt;
  logic [WIDTH-1:0]     inf_r, inf_nxt;
  logic                 infv_r, infv_nxt, halted_r, halted_nxt, ill_r, ill_nxt;
`ifdef BITNET_HW_LOOP_EN
  logic [7:0]           loop_cnt, cnt_nxt;
  logic [I_SIZE-1:0]    loop_start, lstart_nxt;
`endif

  logic [4:0]  opcode;
  logic [10:0] imm;
  assign opcode = instruction_in[15:11];
  assign imm    = instruction_in[10:0];
  assign ip_inc = ip + I_SIZE'(1);

  always_comb begin
    case (imm[10:9])
      2'd0:    sel_ptr = d_ptr;
      2'd1:    sel_ptr = a_ptr;
      default: sel_ptr = h_ptr;
    endcase
    // imm[8:0] is sign-extended; its low ADDR_SIZE bits give the same sum modulo 2^ADDR_SIZE
    new_ptr = (opcode == OPC_SETP) ? imm[ADDR_SIZE-1:0] : sel_ptr + imm[ADDR_SIZE-1:0];
  end

  always_comb begin
    state_nxt  = state;
    ip_nxt     = ip;
    d_nxt      = d_ptr;
    a_nxt      = a_ptr;
    h_nxt      = h_ptr;
    x_nxt      = x_reg;
    y_nxt      = y_reg;
    w_nxt      = w_reg;
    req_nxt    = req_r;
    we_nxt     = we_r;
    ch_nxt     = ch_r;
    addr_nxt   = addr_r;
    wdata_nxt  = wdata_r;
    lsub_nxt   = lsub_r;
    osel_nxt   = osel_r;
    start_nxt  = 1'b0;
    inf_nxt    = inf_r;
    infv_nxt   = 1'b0;
    halted_nxt = halted_r;
    ill_nxt    = 1'b0;
`ifdef BITNET_HW_LOOP_EN
    cnt_nxt    = loop_cnt;
    lstart_nxt = loop_start;
`endif
    case (state)
      S_FETCH: if (instruction_valid_in) begin
        ip_nxt = ip_inc;
        case (opcode)
          OPC_NOP: ;
          OPC_JMP: ip_nxt = imm[I_SIZE-1:0];
          OPC_HALT: begin
            ip_nxt     = ip;
            state_nxt  = S_HALT;
            halted_nxt = 1'b1;
          end
          OPC_SETP, OPC_ADDP: begin
            case (imm[10:9])
              2'd0:    d_nxt = new_ptr;
              2'd1:    a_nxt = new_ptr;
              2'd2:    h_nxt = new_ptr;
              default: ill_nxt = 1'b1;
            endcase
          end
          OPC_LOAD: begin
            lsub_nxt = imm[2:0];
            we_nxt   = 1'b0;
            req_nxt  = 1'b1;
            case (imm[2:0])
              3'd0, 3'd1, 3'd2: begin ch_nxt = 2'd0; addr_nxt = d_ptr; end
              3'd3:             begin ch_nxt = 2'd1; addr_nxt = a_ptr; end
              3'd4:             begin ch_nxt = 2'd2; addr_nxt = h_ptr; end
              default: begin
                req_nxt  = 1'b0;
                we_nxt   = we_r;
                lsub_nxt = lsub_r;
                ill_nxt  = 1'b1;
              end
            endcase
            if (req_nxt) state_nxt = S_WAIT_MEM;
          end
          OPC_STORE: begin
            we_nxt    = 1'b1;
            req_nxt   = 1'b1;
            state_nxt = S_WAIT_MEM;
            if (imm[0]) begin ch_nxt = 2'd2; addr_nxt = h_ptr; wdata_nxt = x_reg; end
            else        begin ch_nxt = 2'd1; addr_nxt = a_ptr; wdata_nxt = w_reg; end
          end
          OPC_ALU: begin
            case (imm[3:0])
              4'd0:    begin x_nxt = y_reg; y_nxt = x_reg; end
              4'd1:    x_nxt = y_reg;
              4'd2:    y_nxt = x_reg;
              4'd3:    x_nxt = x_reg ^ y_reg;
              4'd4:    y_nxt = y_reg ^ x_reg;
              4'd5:    x_nxt = x_reg & y_reg;
              4'd6:    y_nxt = y_reg & x_reg;
              4'd7:    x_nxt = x_reg | y_reg;
              4'd8:    y_nxt = y_reg | x_reg;
              default: ill_nxt = 1'b1;
            endcase
          end
          OPC_OP: begin
            if (imm[1:0] == 2'd3) ill_nxt = 1'b1;
            else begin
              osel_nxt  = imm[1:0];
              start_nxt = 1'b1;
              state_nxt = S_WAIT_OP;
            end
          end
          OPC_EMIT: begin
            inf_nxt  = y_reg;
            infv_nxt = 1'b1;
          end
`ifdef BITNET_HW_LOOP_EN
          OPC_LOOP: begin
            cnt_nxt    = imm[7:0];
            lstart_nxt = ip_inc;
          end
          OPC_ENDLOOP: begin
            if (loop_cnt != 8'd0) begin
              cnt_nxt = loop_cnt - 8'd1;
              ip_nxt  = loop_start;
            end
          end
`endif
          default: ill_nxt = 1'b1;
        endcase
      end
      S_WAIT_MEM: if (mem.mem_ack_in) begin
        req_nxt   = 1'b0;
        state_nxt = S_FETCH;
        if (!we_r) begin
          case (lsub_r)
            3'd0:    x_nxt = mem.mem_rdata_x_in;
            3'd1:    y_nxt = mem.mem_rdata_y_in;
            3'd2:    begin x_nxt = mem.mem_rdata_x_in; y_nxt = mem.mem_rdata_y_in; end
            3'd3:    w_nxt = mem.mem_rdata_x_in;
            default: x_nxt = mem.mem_rdata_x_in;
          endcase
        end
      end
      S_WAIT_OP: if (op_done_in) begin
        state_nxt = S_FETCH;
        case (osel_r)
          2'd0:    y_nxt = op_result_in;
          2'd1:    x_nxt = op_result_in;
          default: w_nxt = op_result_in;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_FETCH;
    else           state <= state_nxt;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ip       <= '0;
      d_ptr    <= '0;
      a_ptr    <= '0;
      h_ptr    <= '0;
      x_reg    <= '0;
      y_reg    <= '0;
      w_reg    <= '0;
      req_r    <= 1'b0;
      we_r     <= 1'b0;
      ch_r     <= 2'd0;
      addr_r   <= '0;
      wdata_r  <= '0;
      lsub_r   <= 3'd0;
      osel_r   <= 2'd0;
      start_r  <= 1'b0;
      inf_r    <= '0;
      infv_r   <= 1'b0;
      halted_r <= 1'b0;
      ill_r    <= 1'b0;
`ifdef BITNET_HW_LOOP_EN
      loop_cnt   <= 8'd0;
      loop_start <= '0;
`endif
    end else begin
      ip       <= ip_nxt;
      d_ptr    <= d_nxt;
      a_ptr    <= a_nxt;
      h_ptr    <= h_nxt;
      x_reg    <= x_nxt;
      y_reg    <= y_nxt;
      w_reg    <= w_nxt;
      req_r    <= req_nxt;
      we_r     <= we_nxt;
      ch_r     <= ch_nxt;
      addr_r   <= addr_nxt;
      wdata_r  <= wdata_nxt;
      lsub_r   <= lsub_nxt;
      osel_r   <= osel_nxt;
      start_r  <= start_nxt;
      inf_r    <= inf_nxt;
      infv_r   <= infv_nxt;
      halted_r <= halted_nxt;
      ill_r    <= ill_nxt;
`ifdef BITNET_HW_LOOP_EN
      loop_cnt   <= cnt_nxt;
      loop_start <= lstart_nxt;
`endif
    end
  end

  assign instruction_addr_out = ip;
  assign mem.mem_req_out      = req_r;
  assign mem.mem_we_out       = we_r;
  assign mem.mem_ch_out       = ch_r;
  assign mem.mem_addr_out     = addr_r;
  assign mem.mem_wdata_out    = wdata_r;
  assign op_start_out         = start_r;
  assign op_sel_out           = osel_r;
  assign x_out                = x_reg;
  assign y_out                = y_reg;
  assign w_out                = w_reg;
  assign inference_out        = inf_r;
  assign inference_valid_out  = infv_r;
  assign halted_out           = halted_r;
  assign illegal_out          = ill_r;

endmodule

// File: tb/tb_bitnet_sequencer.sv
// tb/tb_bitnet_sequencer.sv - directed vector bench for bitnet_sequencer
module tb_bitnet_sequencer;

  localparam int PL = 256;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic [7:0]    instruction_addr_out;
  logic [15:0]   instruction_in = '0;
  logic          instruction_valid_in = 1'b0;
  logic          op_start_out;
  logic [1:0]    op_sel_out;
  logic [DW-1:0] x_out, y_out, w_out, inference_out;
  logic [DW-1:0] op_result_in = '0;
  logic          op_done_in = 1'b0;
  logic          inference_valid_out, halted_out, illegal_out;

  bitnet_sequencer_if #(.ADDR_SIZE(AW), .WIDTH(DW)) mif ();

  bitnet_sequencer #(.PROGRAM_LENGTH(PL), .ADDR_SIZE(AW), .WIDTH(DW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .instruction_addr_out(instruction_addr_out), .instruction_in(instruction_in),
    .instruction_valid_in(instruction_valid_in), .mem(mif),
    .op_start_out(op_start_out), .op_sel_out(op_sel_out),
    .x_out(x_out), .y_out(y_out), .w_out(w_out),
    .op_result_in(op_result_in), .op_done_in(op_done_in),
    .inference_out(inference_out), .inference_valid_out(inference_valid_out),
    .halted_out(halted_out), .illegal_out(illegal_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [15:0]   ins;
    logic          mem;
    int            dly;
    logic [AW-1:0] addr;
    logic [1:0]    ch;
    logic          we;
    logic [DW-1:0] wd, rx, ry, ex, ey, ew;
    logic          ill;
  } vec_t;

  vec_t vt[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] ip_exp = '0;

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [10:0] imm);
    return {op, imm};
  endfunction

  function automatic vec_t mk(input logic [15:0] ins, input logic mem, input int dly,
                              input logic [AW-1:0] addr, input logic [1:0] ch, input logic we,
                              input logic [DW-1:0] wd, input logic [DW-1:0] rx, input logic [DW-1:0] ry,
                              input logic [DW-1:0] ex, input logic [DW-1:0] ey, input logic [DW-1:0] ew,
                              input logic ill);
    vec_t v;
    v.ins = ins; v.mem = mem; v.dly = dly; v.addr = addr; v.ch = ch; v.we = we;
    v.wd = wd; v.rx = rx; v.ry = ry; v.ex = ex; v.ey = ey; v.ew = ew; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk_in);
    instruction_in = v.ins;
    instruction_valid_in = 1'b1;
    @(posedge clk_in); #1;
    instruction_valid_in = 1'b0;
    ip_exp = ip_exp + 8'd1;
    chk($sformatf("v%0d illegal", idx), illegal_out, v.ill);
    chk($sformatf("v%0d ip", idx), instruction_addr_out, ip_exp);
    if (v.mem) begin
      for (int k = 0; k <= v.dly; k++) begin
        chk($sformatf("v%0d req c%0d", idx, k), mif.mem_req_out, 1'b1);
        chk($sformatf("v%0d addr c%0d", idx, k), mif.mem_addr_out, v.addr);
        chk($sformatf("v%0d ch c%0d", idx, k), mif.mem_ch_out, v.ch);
        chk($sformatf("v%0d we c%0d", idx, k), mif.mem_we_out, v.we);
        if (v.we) chk($sformatf("v%0d wdata c%0d", idx, k), mif.mem_wdata_out, v.wd);
        if (k == v.dly) begin
          mif.mem_rdata_x_in = v.rx;
          mif.mem_rdata_y_in = v.ry;
          mif.mem_ack_in = 1'b1;
        end
        @(posedge clk_in); #1;
      end
      mif.mem_ack_in = 1'b0;
      chk($sformatf("v%0d req drop", idx), mif.mem_req_out, 1'b0);
    end
    chk($sformatf("v%0d x", idx), x_out, v.ex);
    chk($sformatf("v%0d y", idx), y_out, v.ey);
    chk($sformatf("v%0d w", idx), w_out, v.ew);
  endtask

  task automatic decode_one(input logic [15:0] ins);
    @(negedge clk_in);
    instruction_in = ins;
    instruction_valid_in = 1'b1;
    @(posedge clk_in); #1;
    instruction_valid_in = 1'b0;
  endtask

  logic [15:0] prog [0:7];
  int starts, emits, ills, exp_emits, exp_ills;
  logic done_flag;

  initial begin
    mif.mem_ack_in = 1'b0;
    mif.mem_rdata_x_in = '0;
    mif.mem_rdata_y_in = '0;

    // register contents after the reset, in execution order
    vt.push_back(mk(enc(3, {2'd0, 9'd5}),    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(enc(4, {2'd0, 9'h1FA}),  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(enc(5, 11'd2), 1, 2, 8'd255, 0, 0, 0, 32'hA1A10001, 32'hB2B20002, 32'hA1A10001, 32'hB2B20002, 0, 0));
    vt.push_back(mk(enc(3, {2'd1, 9'd255}),  0, 0, 0, 0, 0, 0, 0, 0, 32'hA1A10001, 32'hB2B20002, 0, 0));
    vt.push_back(mk(enc(5, 11'd3), 1, 0, 8'd255, 1, 0, 0, 32'hC3C30003, 32'hDEAD, 32'hA1A10001, 32'hB2B20002, 32'hC3C30003, 0));
    vt.push_back(mk(enc(4, {2'd1, 9'd1}),    0, 0, 0, 0, 0, 0, 0, 0, 32'hA1A10001, 32'hB2B20002, 32'hC3C30003, 0));
    vt.push_back(mk(enc(6, 11'd0), 1, 1, 8'd0, 1, 1, 32'hC3C30003, 0, 0, 32'hA1A10001, 32'hB2B20002, 32'hC3C30003, 0));
    vt.push_back(mk(enc(3, {2'd2, 9'h10}),   0, 0, 0, 0, 0, 0, 0, 0, 32'hA1A10001, 32'hB2B20002, 32'hC3C30003, 0));
    vt.push_back(mk(enc(5, 11'd4), 1, 1, 8'h10, 2, 0, 0, 32'h0000FFFF, 32'h1111, 32'h0000FFFF, 32'hB2B20002, 32'hC3C30003, 0));
    vt.push_back(mk(enc(6, 11'd1), 1, 0, 8'h10, 2, 1, 32'h0000FFFF, 0, 0, 32'h0000FFFF, 32'hB2B20002, 32'hC3C30003, 0));
    vt.push_back(mk(enc(7, 11'd0), 0, 0, 0, 0, 0, 0, 0, 0, 32'hB2B20002, 32'h0000FFFF, 32'hC3C30003, 0));
    vt.push_back(mk(enc(7, 11'd3), 0, 0, 0, 0, 0, 0, 0, 0, 32'hB2B2FFFD, 32'h0000FFFF, 32'hC3C30003, 0));
    vt.push_back(mk(enc(7, 11'd6), 0, 0, 0, 0, 0, 0, 0, 0, 32'hB2B2FFFD, 32'h0000FFFD, 32'hC3C30003, 0));
    vt.push_back(mk(enc(7, 11'd7), 0, 0, 0, 0, 0, 0, 0, 0, 32'hB2B2FFFD, 32'h0000FFFD, 32'hC3C30003, 0));
    vt.push_back(mk(enc(7, 11'd8), 0, 0, 0, 0, 0, 0, 0, 0, 32'hB2B2FFFD, 32'hB2B2FFFD, 32'hC3C30003, 0));
    vt.push_back(mk(enc(5, 11'd1), 1, 0, 8'd255, 0, 0, 0, 32'h7777, 32'h0F0F0F0F, 32'hB2B2FFFD, 32'h0F0F0F0F, 32'hC3C30003, 0));
    vt.push_back(mk(enc(7, 11'd5), 0, 0, 0, 0, 0, 0, 0, 0, 32'h02020F0D, 32'h0F0F0F0F, 32'hC3C30003, 0));
    vt.push_back(mk(enc(7, 11'd4), 0, 0, 0, 0, 0, 0, 0, 0, 32'h02020F0D, 32'h0D0D0002, 32'hC3C30003, 0));
    vt.push_back(mk(enc(7, 11'd2), 0, 0, 0, 0, 0, 0, 0, 0, 32'h02020F0D, 32'h02020F0D, 32'hC3C30003, 0));
    vt.push_back(mk(enc(5, 11'd0), 1, 0, 8'd255, 0, 0, 0, 32'h12345678, 32'h9999, 32'h12345678, 32'h02020F0D, 32'hC3C30003, 0));
    vt.push_back(mk(enc(7, 11'd1), 0, 0, 0, 0, 0, 0, 0, 0, 32'h02020F0D, 32'h02020F0D, 32'hC3C30003, 0));
    vt.push_back(mk(enc(20, 11'd0),          0, 0, 0, 0, 0, 0, 0, 0, 32'h02020F0D, 32'h02020F0D, 32'hC3C30003, 1));
    vt.push_back(mk(enc(7, 11'd9),           0, 0, 0, 0, 0, 0, 0, 0, 32'h02020F0D, 32'h02020F0D, 32'hC3C30003, 1));
    vt.push_back(mk(enc(8, 11'd3),           0, 0, 0, 0, 0, 0, 0, 0, 32'h02020F0D, 32'h02020F0D, 32'hC3C30003, 1));
    vt.push_back(mk(enc(5, 11'd5),           0, 0, 0, 0, 0, 0, 0, 0, 32'h02020F0D, 32'h02020F0D, 32'hC3C30003, 1));
    vt.push_back(mk(enc(3, {2'd3, 9'd7}),    0, 0, 0, 0, 0, 0, 0, 0, 32'h02020F0D, 32'h02020F0D, 32'hC3C30003, 1));

    #2;
    chk("rst req", mif.mem_req_out, 0);
    chk("rst ip", instruction_addr_out, 0);
    chk("rst xyw", {x_out, y_out}, 0);
    chk("rst w", w_out, 0);
    chk("rst flags", {op_start_out, op_sel_out, inference_valid_out, halted_out, illegal_out}, 0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

    // stray op_done and ack while idle in FETCH
    @(negedge clk_in);
    op_done_in = 1'b1; op_result_in = 32'hFFFF0000;
    mif.mem_ack_in = 1'b1; mif.mem_rdata_x_in = 32'hEEEEEEEE; mif.mem_rdata_y_in = 32'hEEEEEEEE;
    @(posedge clk_in); #1;
    op_done_in = 1'b0; mif.mem_ack_in = 1'b0;
    chk("stray x", x_out, 32'h02020F0D);
    chk("stray y", y_out, 32'h02020F0D);
    chk("stray w", w_out, 32'hC3C30003);

    // OP 0 with done in the fourth WAIT_OP cycle
    decode_one(enc(8, 11'd0));
    ip_exp = ip_exp + 8'd1;
    chk("op0 start first", op_start_out, 1);
    starts = 0;
    for (int k = 0; k < 4; k++) begin
      if (op_start_out) starts++;
      chk($sformatf("op0 sel c%0d", k), op_sel_out, 0);
      chk($sformatf("op0 x stable c%0d", k), x_out, 32'h02020F0D);
      if (k == 3) begin op_result_in = 32'h13579BDF; op_done_in = 1'b1; end
      @(posedge clk_in); #1;
    end
    op_done_in = 1'b0;
    if (op_start_out) starts++;
    chk("op0 start count", starts, 1);
    chk("op0 y", y_out, 32'h13579BDF);
    chk("op0 ip", instruction_addr_out, ip_exp);

    // OP 1 and OP 2 with done in the start cycle
    decode_one(enc(8, 11'd1));
    chk("op1 sel", op_sel_out, 1);
    op_result_in = 32'h2468ACE0; op_done_in = 1'b1;
    @(posedge clk_in); #1;
    op_done_in = 1'b0;
    chk("op1 x", x_out, 32'h2468ACE0);
    chk("op1 start dropped", op_start_out, 0);
    decode_one(enc(8, 11'd2));
    op_result_in = 32'h0BADF00D; op_done_in = 1'b1;
    @(posedge clk_in); #1;
    op_done_in = 1'b0;
    chk("op2 w", w_out, 32'h0BADF00D);
    chk("op2 y kept", y_out, 32'h13579BDF);

    // reset while a load is outstanding
    decode_one(enc(5, 11'd0));
    chk("rstmem req", mif.mem_req_out, 1);
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    chk("rstmem req drop", mif.mem_req_out, 0);
    chk("rstmem ip", instruction_addr_out, 0);
    chk("rstmem xy", {x_out, y_out}, 0);
    chk("rstmem w", w_out, 0);
    chk("rstmem flags", {mif.mem_we_out, mif.mem_ch_out, op_sel_out, halted_out}, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // program fetched by IP: LOAD Y; LOOP 2; EMIT; ENDLOOP; HALT
    prog[0] = enc(5, 11'd1);
    prog[1] = enc(10, 11'd2);
    prog[2] = enc(9, 11'd0);
    prog[3] = enc(11, 11'd0);
    prog[4] = enc(2, 11'd0);
    for (int k = 5; k < 8; k++) prog[k] = enc(0, 11'd0);
`ifdef BITNET_HW_LOOP_EN
    exp_emits = 3; exp_ills = 0;
`else
    exp_emits = 1; exp_ills = 2;
`endif
    emits = 0; ills = 0; done_flag = 1'b0;
    mif.mem_rdata_y_in = 32'h5A5A1234;
    for (int c = 0; c < 60 && !done_flag; c++) begin
      @(negedge clk_in);
      if (inference_valid_out) emits++;
      if (illegal_out) ills++;
      if (halted_out) begin
        done_flag = 1'b1;
        instruction_valid_in = 1'b0;
        mif.mem_ack_in = 1'b0;
      end else begin
        instruction_in = prog[instruction_addr_out[2:0]];
        instruction_valid_in = 1'b1;
        mif.mem_ack_in = mif.mem_req_out;
      end
    end
    chk("prog halted", done_flag, 1);
    chk("prog emits", emits, exp_emits);
    chk("prog illegal", ills, exp_ills);
    chk("prog inference", inference_out, 32'h5A5A1234);
    chk("prog halt ip", instruction_addr_out, 4);
    repeat (2) @(posedge clk_in);
    #1;
    chk("halt sticky", halted_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
